// File: rtl/comparatore_3bit_checker.sv
// Exhaustive self-test sequencer for a 3-input "a < b < c" comparator:
// walks all 512 {a,b,c} vectors, samples the response and records mismatches.
module comparatore_3bit_checker #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] a,
  output logic [2:0] b,
  output logic [2:0] c,
  input  logic       out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] err_count,
  output logic       fail_valid,
  output logic [8:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int         SETTLE_C  = (SETTLE < 1) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
  localparam bit         NO_HOLD   = (SETTLE_C == 1);
  localparam logic [3:0] HOLD_LAST = 4'((SETTLE_C >= 2) ? (SETTLE_C - 2) : 0);
  localparam logic [8:0] IDX_LAST  = 9'd511;

  function automatic logic golden(input logic [8:0] v);
    golden = (v[8:6] < v[5:3]) && (v[5:3] < v[2:0]);
  endfunction

  state_t     state_r, state_s;
  logic [8:0] idx_r, idx_s;
  logic [3:0] settle_r, settle_s;
  logic [9:0] err_count_r, err_count_s;
  logic       fail_valid_r, fail_valid_s;
  logic [8:0] fail_vec_r, fail_vec_s;
  logic       pass_r, pass_s;
  logic       done_r, done_s;
  logic       busy_r, busy_s;
  logic [8:0] vec_r, vec_s;
  logic       mismatch_s;

  // Next-state, result bookkeeping and registered-output precomputation.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    settle_s     = settle_r;
    err_count_s  = err_count_r;
    fail_valid_s = fail_valid_r;
    fail_vec_s   = fail_vec_r;
    pass_s       = pass_r;
    mismatch_s   = (out != golden(idx_r));

    case (state_r)
      IDLE: begin
        if (start) begin
          idx_s        = 9'd0;
          settle_s     = 4'd0;
          err_count_s  = 10'd0;
          fail_valid_s = 1'b0;
          fail_vec_s   = 9'd0;
          pass_s       = 1'b0;
          state_s      = NO_HOLD ? SAMPLE : HOLD;
        end else begin
          state_s = IDLE;
        end
      end
      HOLD: begin
        if (settle_r >= HOLD_LAST) begin
          settle_s = 4'd0;
          state_s  = SAMPLE;
        end else begin
          settle_s = settle_r + 4'd1;
        end
      end
      SAMPLE: begin
        if (mismatch_s) begin
          err_count_s = err_count_r + 10'd1;
          if (!fail_valid_r) begin
            fail_valid_s = 1'b1;
            fail_vec_s   = idx_r;
          end else begin
            fail_valid_s = fail_valid_r;
          end
        end else begin
          err_count_s = err_count_r;
        end
        // pass reflects the count including this final sample.
        if (idx_r == IDX_LAST) begin
          pass_s  = (err_count_s == 10'd0);
          state_s = FINISH;
        end else begin
          idx_s    = idx_r + 9'd1;
          settle_s = 4'd0;
          state_s  = NO_HOLD ? SAMPLE : HOLD;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s == HOLD) || (state_s == SAMPLE);
    done_s = (state_s == FINISH);
    if (busy_s) begin
      vec_s = idx_s;
    end else begin
      vec_s = 9'd0;
    end
  end

  // State and output registers; reset wins over any simultaneous start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      idx_r        <= 9'd0;
      settle_r     <= 4'd0;
      err_count_r  <= 10'd0;
      fail_valid_r <= 1'b0;
      fail_vec_r   <= 9'd0;
      pass_r       <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      vec_r        <= 9'd0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      settle_r     <= settle_s;
      err_count_r  <= err_count_s;
      fail_valid_r <= fail_valid_s;
      fail_vec_r   <= fail_vec_s;
      pass_r       <= pass_s;
      done_r       <= done_s;
      busy_r       <= busy_s;
      vec_r        <= vec_s;
    end
  end

  assign a          = vec_r[8:6];
  assign b          = vec_r[5:3];
  assign c          = vec_r[2:0];
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_count  = err_count_r;
  assign fail_valid = fail_valid_r;
  assign fail_vec   = fail_vec_r;

endmodule

// File: doc/comparatore_3bit_checker.md
COMPARATORE_3BIT_CHECKER -- requirements
Module: comparatore_3bit_checker

Interface
REQ-001 Parameter: SETTLE, default 2, number of clock cycles each vector is held before its response is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin an exhaustive run.
REQ-005 a  output  3  operand a, driven to the comparator under test.
REQ-006 b  output  3  operand b, driven to the comparator under test.
REQ-007 c  output  3  operand c, driven to the comparator under test.
REQ-008 out  input  1  response returned by the comparator under test.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  one-cycle pulse when a run completes.
REQ-011 pass  output  1  high after a run with zero mismatches; held until the next start.
REQ-012 err_count  output  10  number of mismatching vectors in the last or current run.
REQ-013 fail_valid  output  1  high once at least one mismatch has been recorded in the current run.
REQ-014 fail_vec  output  9  index {a,b,c} of the first mismatching vector.

Function
REQ-015 Golden model: expected = 1 iff a < b and b < c, with unsigned comparison; otherwise 0.
REQ-016 States: IDLE, HOLD, SAMPLE, FINISH.
REQ-017 Vector index idx is 9 bits, with a = idx[8:6], b = idx[5:3], c = idx[2:0]; vectors are applied in ascending order from 0 to 511.
REQ-018 IDLE: busy=0; a, b and c hold 0; start=1 moves to HOLD with idx=0, err_count=0, fail_valid=0, fail_vec=0, pass=0.
REQ-019 HOLD: a, b and c reflect idx; the settle counter counts SETTLE-1 cycles, then the block moves to SAMPLE.
REQ-020 SAMPLE: out is compared with the expected value for the idx currently driven; each vector occupies exactly SETTLE cycles on a, b and c.
REQ-021 On mismatch: err_count increments by 1; if fail_valid=0, fail_vec=idx and fail_valid=1.
REQ-022 After SAMPLE: if idx=511, go to FINISH; otherwise idx increments and the block returns to HOLD (or stays in SAMPLE when SETTLE=1).
REQ-023 FINISH lasts one cycle: done=1, pass=(err_count=0 including the final sample), busy=0 from the next cycle, and the block returns to IDLE.
REQ-024 Full-run latency: the done pulse occurs 512*SETTLE+1 cycles after the cycle in which start was sampled.
REQ-025 busy is 1 in HOLD and SAMPLE and 0 in IDLE and FINISH.
REQ-026 start is ignored while busy=1 or in FINISH.
REQ-027 err_count cannot exceed 512, so the 10-bit counter never wraps.
REQ-028 Results (pass, err_count, fail_valid, fail_vec) remain stable in IDLE until the next accepted start.

Reset
REQ-029 rst=1 at a clock edge forces IDLE regardless of state, including mid-run, and overrides a simultaneous start.
REQ-030 Reset values: a=b=c=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, settle counter=0, idx=0.
REQ-031 The first start is accepted on the first edge after rst is deasserted.

Verification
REQ-032 Reset then idle: after rst, hold start=0 for 20 cycles -> all outputs remain 0 and a=b=c=0.
REQ-033 Correct comparator model, SETTLE=2: pulse start -> busy high for 1024 cycles, done at cycle 1025, pass=1, err_count=0, fail_valid=0.
REQ-034 Comparator stuck at 0 -> err_count=56, fail_vec=10 (a=0, b=1, c=2), fail_valid=1, pass=0.
REQ-035 Comparator stuck at 1 -> err_count=456, fail_vec=0, pass=0.
REQ-036 Pulse start again at idx=100 during a run -> the run is unaffected, one done pulse occurs, and results match a single run.
REQ-037 Assert rst at idx=300 during a run -> next edge gives IDLE with all outputs at reset values; a later start runs a full 512-vector pass from idx 0.
